// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and types for the UART receive path.
// Revision : 1.0 - initial circular receive FIFO release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module   : uart_fifo_mem
// Brief    : DEPTH x DATA_W storage, synchronous write, registered read port.
// Revision : 1.0 - initial circular receive FIFO release
// ============================================================================
`default_nettype none

module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the array so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A same-address read and write returns the old word (oldest entry when full).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : uart_fifo_mem

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Circular receive FIFO with status, sticky errors and flush.
// Revision : 1.0 - initial circular receive FIFO release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = UART_FIFO_DEPTH,
    parameter int AF_LEVEL = 12,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AF_CNT    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc, rd_acc;
    logic ovf_set, unf_set;

    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_CNT);

    // Flush suppresses both requests, so they neither move state nor raise errors.
    assign rd_acc  = rd_en && !flush && !empty;
    assign wr_acc  = wr_en && !flush && (!full || rd_acc);
    assign ovf_set = wr_en && !flush && !wr_acc;
    assign unf_set = rd_en && !flush && !rd_acc;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q  && !err_clr) || ovf_set;
        underflow_d = (underflow_q && !err_clr) || unf_set;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (DEPTH 16, AF 12).
// Revision : 1.0 - initial circular receive FIFO release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       wr_en;
    uart_byte_t wr_data;
    logic       rd_en;
    uart_byte_t rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int vecs;
    int errs;

    uart_rx_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (12)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
        vecs++;
        if ({empty, full, almost_full, count, rd_data, rd_valid, overflow, underflow} !==
            {1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: e=%b f=%b af=%b cnt=%0d rd=%h v=%b ov=%b un=%b, want e=1 f=0 af=0 cnt=0 rd=00 v=0 ov=0 un=0",
                     empty, full, almost_full, count, rd_data, rd_valid, overflow, underflow);
        end
    endtask

    task automatic test_basic();
        uart_byte_t exp_b [3];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp_b[i];
            cycle();
        end
        wr_en = 1'b0;
        vecs++;
        if (count !== 5'd3 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL basic_fill: cnt=%0d v=%b, want cnt=3 v=0", count, rd_valid);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vecs++;
            if (rd_valid !== 1'b1 || rd_data !== exp_b[i]) begin
                errs++;
                $display("FAIL basic_read%0d: v=%b rd=%h, want v=1 rd=%h", i, rd_valid, rd_data, exp_b[i]);
            end
        end
        rd_en = 1'b0;
        cycle();
        vecs++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'hC3) begin
            errs++;
            $display("FAIL basic_drained: v=%b cnt=%0d e=%b rd=%h, want v=0 cnt=0 e=1 rd=c3",
                     rd_valid, count, empty, rd_data);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            cycle();
            vecs++;
            if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16) ||
                empty !== 1'b0) begin
                errs++;
                $display("FAIL fill_status%0d: cnt=%0d af=%b f=%b e=%b, want cnt=%0d af=%b f=%b e=0",
                         i, count, almost_full, full, empty, i + 1, (i + 1 >= 12), (i + 1 == 16));
            end
        end
        wr_data = 8'hFF;
        cycle();
        wr_en = 1'b0;
        vecs++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL overflow_drop: cnt=%0d f=%b ov=%b un=%b, want cnt=16 f=1 ov=1 un=0",
                     count, full, overflow, underflow);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            vecs++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errs++;
                $display("FAIL full_read%0d: v=%b rd=%h, want v=1 rd=%h", i, rd_valid, rd_data, 8'(i));
            end
        end
        rd_en = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        vecs++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL overflow_clear: cnt=%0d e=%b ov=%b v=%b, want cnt=0 e=1 ov=0 v=0",
                     count, empty, overflow, rd_valid);
        end
    endtask

    task automatic test_full_rw_wrap();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            cycle();
        end
        wr_data = 8'h55;
        rd_en   = 1'b1;
        cycle();
        wr_en = 1'b0;
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00 || count !== 5'd16 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL full_rw: v=%b rd=%h cnt=%0d ov=%b, want v=1 rd=00 cnt=16 ov=0",
                     rd_valid, rd_data, count, overflow);
        end
        for (int i = 1; i <= 16; i++) begin
            cycle();
            vecs++;
            if (rd_valid !== 1'b1 || rd_data !== ((i == 16) ? 8'h55 : 8'(i))) begin
                errs++;
                $display("FAIL wrap_read%0d: v=%b rd=%h, want v=1 rd=%h", i, rd_valid, rd_data,
                         (i == 16) ? 8'h55 : 8'(i));
            end
        end
        rd_en = 1'b0;
        cycle();
        vecs++;
        if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL wrap_drained: cnt=%0d e=%b un=%b, want cnt=0 e=1 un=0", count, empty, underflow);
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        cycle();
        wr_en = 1'b0;
        vecs++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1 || count !== 5'd1 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL empty_rw: v=%b un=%b cnt=%0d ov=%b, want v=0 un=1 cnt=1 ov=0",
                     rd_valid, underflow, count, overflow);
        end
        cycle();
        rd_en = 1'b0;
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin
            errs++;
            $display("FAIL after_underflow_read: v=%b rd=%h cnt=%0d, want v=1 rd=77 cnt=0",
                     rd_valid, rd_data, count);
        end
        // A rejected read in the same cycle as err_clr keeps the flag set.
        rd_en = 1'b1; err_clr = 1'b1;
        cycle();
        rd_en = 1'b0;
        vecs++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL err_clr_set_wins: un=%b v=%b, want un=1 v=0", underflow, rd_valid);
        end
        cycle();
        err_clr = 1'b0;
        vecs++;
        if (underflow !== 1'b0) begin
            errs++;
            $display("FAIL underflow_clear: un=%b, want un=0", underflow);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hE0 + 8'(i);
            cycle();
        end
        flush = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        cycle();
        flush = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        vecs++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0 ||
            underflow !== 1'b0 || rd_data !== 8'h77) begin
            errs++;
            $display("FAIL flush: cnt=%0d e=%b v=%b ov=%b un=%b rd=%h, want cnt=0 e=1 v=0 ov=0 un=0 rd=77",
                     count, empty, rd_valid, overflow, underflow, rd_data);
        end
        wr_en = 1'b1; wr_data = 8'h3C;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h3C || count !== 5'd0) begin
            errs++;
            $display("FAIL post_flush_rw: v=%b rd=%h cnt=%0d, want v=1 rd=3c cnt=0", rd_valid, rd_data, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h90 + 8'(i);
            cycle();
        end
        rd_en = 1'b1;
        cycle();
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h90 || count !== 5'd4) begin
            errs++;
            $display("FAIL pre_reset_burst: v=%b rd=%h cnt=%0d, want v=1 rd=90 cnt=4", rd_valid, rd_data, count);
        end
        // Assert reset between clock edges to prove it acts asynchronously.
        #2;
        rstn = 1'b0;
        #1;
        vecs++;
        if ({empty, full, almost_full, count, rd_data, rd_valid, overflow, underflow} !==
            {1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL async_reset: e=%b f=%b af=%b cnt=%0d rd=%h v=%b ov=%b un=%b, want e=1 f=0 af=0 cnt=0 rd=00 v=0 ov=0 un=0",
                     empty, full, almost_full, count, rd_data, rd_valid, overflow, underflow);
        end
        idle_inputs();
        cycle();
        rstn = 1'b1;
        cycle();
        vecs++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: cnt=%0d e=%b v=%b, want cnt=0 e=1 v=0", count, empty, rd_valid);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_rw_wrap();
        test_underflow();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_uart_rx_fifo

`default_nettype wire
